// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812 strip driver.
package ws2812_pkg;

  // Transmit FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StBitHi,
    StBitLo,
    StLatch,
    StDone
  } state_e;

  // COLOR_ORDER encodings: byte order on the wire.
  localparam int unsigned ColorGrb = 0;
  localparam int unsigned ColorRgb = 1;

  // floor(f_clk * ns / 1e9); 64-bit product so large clocks cannot overflow.
  function automatic int unsigned ns_to_cycles(input int unsigned f_clk, input int unsigned ns);
    longint unsigned prod;
    prod = 64'(f_clk) * 64'(ns);
    return 32'(prod / 64'd1_000_000_000);
  endfunction

  function automatic int unsigned us_to_cycles(input int unsigned f_clk, input int unsigned us);
    return ns_to_cycles(f_clk, us * 32'd1000);
  endfunction

  // Reorder a {R,G,B} pixel into the byte order sent on the wire.
  function automatic logic [23:0] wire_order(input logic [23:0] rgb, input int unsigned order);
    if (order == ColorRgb) return rgb;
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Pixel store: one write port, one synchronous read port with one cycle of latency.
// Contents are deliberately not reset.
module ws2812_pixel_ram #(
  parameter int unsigned Depth = 8,
  parameter int unsigned AddrW = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [23:0]      wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [23:0]      rdata
);

  logic [23:0] mem [Depth];

  // Write and registered read; a read of the address being written returns old data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ws2812_strip_driver.sv
// WS2812 strip driver: serialises N_LEDS pixels from a local RAM onto dout, then holds
// the line low for the latch period. All outputs are registered off the FSM state.
module ws2812_strip_driver
  import ws2812_pkg::*;
#(
  parameter int unsigned F_CLK       = 50_000_000,
  parameter int unsigned N_LEDS      = 8,
  parameter int unsigned T0H_NS      = 400,
  parameter int unsigned T1H_NS      = 800,
  parameter int unsigned TBIT_NS     = 1250,
  parameter int unsigned TRESET_US   = 80,
  parameter int unsigned COLOR_ORDER = 0,
  localparam int unsigned AW         = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  output logic          wr_err,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          latching,
  output logic          dout
);

  localparam int unsigned T0hCyc    = ns_to_cycles(F_CLK, T0H_NS);
  localparam int unsigned T1hCyc    = ns_to_cycles(F_CLK, T1H_NS);
  localparam int unsigned TbitCyc   = ns_to_cycles(F_CLK, TBIT_NS);
  localparam int unsigned TresetCyc = us_to_cycles(F_CLK, TRESET_US);
  localparam int unsigned CntMax    = (TresetCyc > TbitCyc) ? TresetCyc : TbitCyc;
  localparam int unsigned CntW      = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] T0hLast    = CntW'(T0hCyc - 1);
  localparam logic [CntW-1:0] T1hLast    = CntW'(T1hCyc - 1);
  localparam logic [CntW-1:0] TbitLast   = CntW'(TbitCyc - 1);
  localparam logic [CntW-1:0] TresetLast = CntW'(TresetCyc - 1);
  localparam logic [AW-1:0]   PixLast    = AW'(N_LEDS - 1);
  localparam logic [AW:0]     NLedsW     = (AW + 1)'(N_LEDS);

  if (T0hCyc == 0 || T1hCyc == 0 || T1hCyc >= TbitCyc || T0hCyc >= TbitCyc ||
      TresetCyc == 0 || N_LEDS < 1 || N_LEDS > 1024) begin : g_bad_params
    $error("ws2812_strip_driver: invalid timing or size parameters");
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      bit_q, bit_d;
  logic [AW-1:0]   pix_q, pix_d;
  logic [23:0]     shreg_q, shreg_d;
  logic [1:0]      run_q;
  logic            dout_q, latching_q, done_q, wr_err_q;
  logic [AW-1:0]   rd_addr;
  logic [23:0]     rd_data;
  logic            wr_ok;
  logic [CntW-1:0] hi_last;

  // Reset deassertion synchroniser; the FSM may only leave idle once run_q[1] is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= '0;
    else        run_q <= {run_q[0], 1'b1};
  end

  // Busy spans the registered done pulse, which lands one cycle after the FSM's DONE state.
  assign busy  = (state_q != StIdle) | done_q;
  assign wr_ok = ({1'b0, wr_addr} < NLedsW) & ~busy;

  ws2812_pixel_ram #(
    .Depth(N_LEDS),
    .AddrW(AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en & wr_ok),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  // Read pixel 0 while idle, otherwise prefetch the next pixel for a gapless boundary.
  always_comb begin
    rd_addr = '0;
    if (state_q != StIdle && pix_q != PixLast) rd_addr = pix_q + AW'(1);
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state logic; cnt counts cycles within the current bit period or latch period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    pix_d   = pix_q;
    shreg_d = shreg_q;
    hi_last = shreg_q[23] ? T1hLast : T0hLast;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        pix_d = '0;
        if (start && run_q[1] && !done_q) state_d = StLoad;
      end
      StLoad: begin
        shreg_d = wire_order(rd_data, COLOR_ORDER);
        cnt_d   = '0;
        state_d = StBitHi;
      end
      StBitHi: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == hi_last) state_d = StBitLo;
      end
      StBitLo: begin
        if (cnt_q == TbitLast) begin
          cnt_d = '0;
          if (bit_q == 5'd23) begin
            bit_d = '0;
            if (pix_q == PixLast) begin
              state_d = StLatch;
            end else begin
              pix_d   = pix_q + AW'(1);
              shreg_d = wire_order(rd_data, COLOR_ORDER);
              state_d = StBitHi;
            end
          end else begin
            bit_d   = bit_q + 5'd1;
            shreg_d = {shreg_q[22:0], 1'b0};
            state_d = StBitHi;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLatch: begin
        if (cnt_q == TresetLast) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered outputs: glitch-free line drive and strobes aligned with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= 1'b0;
      latching_q <= 1'b0;
      done_q     <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      dout_q     <= (state_q == StBitHi);
      latching_q <= (state_q == StLatch);
      done_q     <= (state_q == StDone);
      wr_err_q   <= wr_en & ~wr_ok;
    end
  end

  assign dout     = dout_q;
  assign latching = latching_q;
  assign done     = done_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Bench for ws2812_strip_driver: two instances (3 pixels GRB, 1 pixel RGB) checked every
// cycle against a frame-timeline model, plus hand-computed frame statistics.
module tb_ws2812_strip_driver;

  localparam int T0H  = 20;
  localparam int T1H  = 40;
  localparam int TBIT = 62;
  localparam int TRES = 4000;
  localparam int NA   = 3;
  localparam int NB   = 1;
  localparam int FA   = 2 + 24 * NA * TBIT + TRES + 1;
  localparam int FB   = 2 + 24 * NB * TBIT + TRES + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] wr_data;
  logic        wr_en_a, start_a, wr_err_a, busy_a, done_a, latching_a, dout_a;
  logic [1:0]  wr_addr_a;
  logic        wr_en_b, start_b, wr_err_b, busy_b, done_b, latching_b, dout_b;
  logic [0:0]  wr_addr_b;

  always #5 clk = ~clk;

  ws2812_strip_driver #(.N_LEDS(NA), .COLOR_ORDER(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data),
    .wr_err(wr_err_a), .start(start_a), .busy(busy_a), .done(done_a),
    .latching(latching_a), .dout(dout_a)
  );

  ws2812_strip_driver #(.N_LEDS(NB), .COLOR_ORDER(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data),
    .wr_err(wr_err_b), .start(start_b), .busy(busy_b), .done(done_b),
    .latching(latching_b), .dout(dout_b)
  );

  // ---------------- model ----------------
  function automatic logic [23:0] to_wire(input logic [23:0] p, input bit rgb);
    return rgb ? p : {p[15:8], p[23:16], p[7:0]};
  endfunction

  // Expected {dout, busy, latching, done} at cycle k of a frame (k=0: cycle after start edge).
  function automatic logic [3:0] exp_vec(input bit act, input int k, input int n,
                                         input logic [71:0] fb);
    logic [3:0] r;
    int tb, b, p;
    r  = '0;
    tb = 24 * n * TBIT;
    if (act) begin
      r[2] = 1'b1;
      if (k >= 2 && k < 2 + tb) begin
        b    = (k - 2) / TBIT;
        p    = (k - 2) % TBIT;
        r[3] = (p < (fb[71-b] ? T1H : T0H));
      end else if (k >= 2 + tb && k < 2 + tb + TRES) begin
        r[1] = 1'b1;
      end else if (k == 2 + tb + TRES) begin
        r[0] = 1'b1;
      end
    end
    return r;
  endfunction

  logic [23:0] mem_a [NA];
  logic [23:0] mem_b;
  bit          act_a, act_b, experr_a, experr_b;
  int          k_a, k_b;
  logic [71:0] fb_a;
  logic [23:0] fb_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_a <= 0; k_a <= 0; experr_a <= 0;
      act_b <= 0; k_b <= 0; experr_b <= 0;
    end else begin
      experr_a <= wr_en_a && (act_a || int'(wr_addr_a) >= NA);
      if (wr_en_a && !act_a && int'(wr_addr_a) < NA) mem_a[wr_addr_a] <= wr_data;
      if (act_a) begin
        if (k_a + 1 == FA) act_a <= 0;
        k_a <= k_a + 1;
      end else if (start_a) begin
        act_a <= 1; k_a <= 0;
        fb_a  <= {to_wire(mem_a[0], 0), to_wire(mem_a[1], 0), to_wire(mem_a[2], 0)};
      end
      experr_b <= wr_en_b && (act_b || int'(wr_addr_b) >= NB);
      if (wr_en_b && !act_b && int'(wr_addr_b) < NB) mem_b <= wr_data;
      if (act_b) begin
        if (k_b + 1 == FB) act_b <= 0;
        k_b <= k_b + 1;
      end else if (start_b) begin
        act_b <= 1; k_b <= 0;
        fb_b  <= to_wire(mem_b, 1);
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_fail = 0;
  int hi_a, lat_a, bcyc_a, rise_a, hi1_a, dn_a;
  int hi_b, lat_b, bcyc_b, rise_b, hi1_b, dn_b;
  bit running;

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic mon_step();
    logic [4:0] ga, wa, gb, wb;
    ga = {dout_a, busy_a, latching_a, done_a, wr_err_a};
    wa = {exp_vec(act_a, k_a, NA, fb_a), experr_a};
    gb = {dout_b, busy_b, latching_b, done_b, wr_err_b};
    wb = {exp_vec(act_b, k_b, NB, {fb_b, 48'b0}), experr_b};
    n_cmp++;
    if (ga !== wa) begin
      n_fail++;
      $display("FAIL cycle_a t=%0t k=%0d got %b want %b", $time, k_a, ga, wa);
    end
    n_cmp++;
    if (gb !== wb) begin
      n_fail++;
      $display("FAIL cycle_b t=%0t k=%0d got %b want %b", $time, k_b, gb, wb);
    end
    if (act_a && k_a == 0) begin hi_a = 0; lat_a = 0; bcyc_a = 0; rise_a = -1; hi1_a = 0; end
    if (act_b && k_b == 0) begin hi_b = 0; lat_b = 0; bcyc_b = 0; rise_b = -1; hi1_b = 0; end
    hi_a += int'(dout_a); lat_a += int'(latching_a); bcyc_a += int'(busy_a);
    hi_b += int'(dout_b); lat_b += int'(latching_b); bcyc_b += int'(busy_b);
    if (dout_a && rise_a < 0) rise_a = k_a;
    if (dout_b && rise_b < 0) rise_b = k_b;
    if (act_a && k_a >= 2 && k_a < 2 + TBIT) hi1_a += int'(dout_a);
    if (act_b && k_b >= 2 && k_b < 2 + TBIT) hi1_b += int'(dout_b);
    dn_a += int'(done_a);
    dn_b += int'(done_b);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wr_a(input logic [1:0] a, input logic [23:0] d);
    wr_en_a = 1'b1; wr_addr_a = a; wr_data = d;
    @(negedge clk);
    wr_en_a = 1'b0;
  endtask

  task automatic wr_b(input logic [0:0] a, input logic [23:0] d);
    wr_en_b = 1'b1; wr_addr_b = a; wr_data = d;
    @(negedge clk);
    wr_en_b = 1'b0;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done(input bit sel_b, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel_b ? done_b : done_a) && n < 20000);
    chk({nm, "_done_seen"}, int'(sel_b ? done_b : done_a), 1);
  endtask

  initial begin
    int d0, n;
    wr_en_a = 0; wr_addr_a = '0; start_a = 0;
    wr_en_b = 0; wr_addr_b = '0; start_b = 0;
    wr_data = '0;
    hi_a = 0; lat_a = 0; bcyc_a = 0; rise_a = -1; hi1_a = 0; dn_a = 0;
    hi_b = 0; lat_b = 0; bcyc_b = 0; rise_b = -1; hi1_b = 0; dn_b = 0;
    running = 1'b1;
    #1 rst_n = 1'b0;
    fork
      begin
        while (running) begin
          @(negedge clk);
          mon_step();
        end
      end
      begin
        repeat (3) @(negedge clk);
        chk("reset_outs_a", int'({dout_a, busy_a, latching_a, done_a, wr_err_a}), 0);
        chk("reset_outs_b", int'({dout_b, busy_b, latching_b, done_b, wr_err_b}), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Pixel loads and rejected out-of-range writes.
        wr_a(2'd0, 24'hAAAAAA);
        chk("wr_ok_err_low", int'(wr_err_a), 0);
        wr_a(2'd1, 24'h555555);
        wr_a(2'd2, 24'h000001);
        wr_a(2'd3, 24'hFFFFFF);
        chk("wr_oob_err_a", int'(wr_err_a), 1);
        wr_b(1'b0, 24'hFF0000);
        chk("wr_err_pulse_end", int'(wr_err_a), 0);
        wr_b(1'b1, 24'h00FF00);
        chk("wr_oob_err_b", int'(wr_err_b), 1);
        @(negedge clk);

        // First frames on both instances.
        start_a = 1'b1; start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        repeat (100) @(negedge clk);
        wr_a(2'd0, 24'h123456);
        chk("wr_busy_err", int'(wr_err_a), 1);
        pulse_start_a();
        wait_done(1'b1, "frame_b");
        repeat (2) @(negedge clk);
        chk("b_high_cycles", hi_b, 640);
        chk("b_latch_cycles", lat_b, 4000);
        chk("b_busy_cycles", bcyc_b, 5491);
        chk("b_first_rise", rise_b, 2);
        chk("b_first_bit_high", hi1_b, 40);
        wait_done(1'b0, "frame_a");
        repeat (2) @(negedge clk);
        chk("a_high_cycles", hi_a, 1940);
        chk("a_latch_cycles", lat_a, 4000);
        chk("a_busy_cycles", bcyc_a, 8467);
        chk("a_first_rise", rise_a, 2);
        chk("a_first_bit_high", hi1_a, 40);
        chk("a_done_count", dn_a, 1);

        // Readback frame: rejected write must not have changed pixel 0.
        pulse_start_a();
        wait_done(1'b0, "readback");
        repeat (2) @(negedge clk);
        chk("readback_high_cycles", hi_a, 1940);

        // Reset in the middle of pixel 1, bit 5 (a 1 bit, phase 10).
        pulse_start_a();
        n = 0;
        while (!(act_a && k_a == 2 + 29 * TBIT + 10) && n < 5000) begin
          @(negedge clk);
          n++;
        end
        chk("abort_reached", int'(act_a), 1);
        #2;
        chk("abort_dout_before", int'(dout_a), 1);
        d0 = dn_a;
        rst_n = 1'b0;
        #1;
        chk("abort_dout_now", int'(dout_a), 0);
        chk("abort_busy_now", int'(busy_a), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_no_done", dn_a, d0);
        pulse_start_a();
        wait_done(1'b0, "restart");
        repeat (2) @(negedge clk);
        chk("restart_high_cycles", hi_a, 1940);
        chk("restart_first_bit_high", hi1_a, 40);
        chk("restart_done_count", dn_a, d0 + 1);

        // Start held high: back-to-back frames with a single idle cycle between.
        start_b = 1'b1;
        wait_done(1'b1, "b2b_first");
        @(negedge clk);
        chk("b2b_gap_low", int'(busy_b), 0);
        @(negedge clk);
        chk("b2b_gap_high", int'(busy_b), 1);
        start_b = 1'b0;
        wait_done(1'b1, "b2b_second");
        repeat (3) @(negedge clk);
        chk("b2b_idle_after", int'(busy_b), 0);
        running = 1'b0;
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812_strip_driver.md
WS2812_STRIP_DRIVER -- requirements
Module: ws2812_strip_driver

Interface
REQ-001 SHALL have parameter F_CLK, default 50_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter N_LEDS, default 8, pixels per frame, range 1..1024.
REQ-003 SHALL have parameter T0H_NS, default 400, high time of a 0 bit in ns.
REQ-004 SHALL have parameter T1H_NS, default 800, high time of a 1 bit in ns.
REQ-005 SHALL have parameter TBIT_NS, default 1250, total bit period in ns.
REQ-006 SHALL have parameter TRESET_US, default 80, latch (low) time after a frame in us.
REQ-007 SHALL have parameter COLOR_ORDER, default 0; 0 = GRB on wire, 1 = RGB on wire.
REQ-008 SHALL use one clock and an asynchronous, active-low reset.
REQ-009 clk  in  1  system clock, all logic on rising edge.
REQ-010 rst_n  in  1  asynchronous active-low reset.
REQ-011 wr_en  in  1  pixel write strobe, one write per cycle.
REQ-012 wr_addr  in  clog2(N_LEDS) (min 1)  pixel index.
REQ-013 wr_data  in  24  pixel {R[23:16],G[15:8],B[7:0]}.
REQ-014 wr_err  out  1  one-cycle pulse: write rejected.
REQ-015 start  in  1  frame request, level sampled each cycle.
REQ-016 busy  out  1  high from accepted start until done pulse inclusive.
REQ-017 done  out  1  one-cycle pulse at end of latch period.
REQ-018 latching  out  1  high during latch (reset-low) period.
REQ-019 dout  out  1  WS2812 serial data line.

Function
REQ-020 Cycle counts SHALL be floor(F_CLK/1e6 * ns / 1000): defaults give T0H=20, T1H=40, TBIT=62, TRESET=4000 cycles.
REQ-021 FSM states SHALL be IDLE, LOAD, BIT_HI, BIT_LO, LATCH, DONE.
REQ-022 IDLE: start=1 -> LOAD, busy=1 next cycle; pixel RAM read of index 0 issued.
REQ-023 LOAD: one cycle, captures pixel into 24-bit shift register reordered per COLOR_ORDER -> BIT_HI.
REQ-024 dout SHALL first rise exactly 2 cycles after the clock edge sampling start.
REQ-025 BIT_HI: dout=1 for T1H cycles if current bit is 1, else T0H cycles -> BIT_LO.
REQ-026 BIT_LO: dout=0 until bit period reaches TBIT cycles; then next bit (BIT_HI), or LATCH after bit 23 of pixel N_LEDS-1.
REQ-027 Bits SHALL be sent MSB-first per wire byte order; pixels in ascending index, no gap between pixels or bytes.
REQ-028 Next pixel SHALL be prefetched during the current pixel so the 24->next pixel boundary is contiguous.
REQ-029 LATCH: dout=0, latching=1 for exactly TRESET cycles -> DONE.
REQ-030 DONE: done=1 one cycle, busy=1 this cycle -> IDLE (busy=0 next cycle).
REQ-031 start while busy SHALL be ignored (no queueing); start held high in IDLE after DONE starts a new frame.
REQ-032 wr_en while busy, or wr_addr >= N_LEDS, SHALL NOT modify RAM and SHALL pulse wr_err the next cycle.
REQ-033 Accepted write SHALL be visible to a start asserted in the following cycle.
REQ-034 Total frame time SHALL be 2 + 24*N_LEDS*TBIT + TRESET + 1 cycles from start sample to busy low.

Reset
REQ-035 rst_n low SHALL immediately force dout=0, busy=0, done=0, latching=0, wr_err=0, state IDLE, counters 0.
REQ-036 Reset mid-frame SHALL abort transmission; no done pulse; next start sends full frame from pixel 0.
REQ-037 Pixel RAM contents SHALL NOT be cleared by reset (undefined at power-up).
REQ-038 Reset deassertion SHALL be synchronised to clk before the FSM leaves IDLE.

Structure
REQ-039 Package ws2812_pkg SHALL hold the state enum, COLOR_ORDER encodings, and the ns/us-to-cycles constant function.
REQ-040 Pixel storage SHALL be sub-module ws2812_pixel_ram: N_LEDS x 24, one write port, one synchronous read port, latency 1.
REQ-041 Counter widths SHALL derive from computed cycle constants; elaboration SHALL fail if T1H >= TBIT or T0H = 0.

Verification
REQ-042 N_LEDS=1, write 0xFF0000, start -> dout: 8 bits 0 (T0H=20 hi), 8 bits 1 (40 hi), 8 bits 0, each 62 cycles; latching 4000 cycles; done once.
REQ-043 COLOR_ORDER=1, same data -> first 8 bits are 1s; frame length 2+1488+4000+1 cycles.
REQ-044 N_LEDS=3, pixels 0xAAAAAA/0x555555/0x000001 -> 72 contiguous periods of 62 cycles, last bit 1 (40 hi).
REQ-045 wr_addr=3 with N_LEDS=3, and write during busy -> wr_err pulses, readback frame unchanged.
REQ-046 rst_n low at pixel 1 bit 5 -> dout=0 same cycle, no done; restart sends pixel 0 first.
REQ-047 start held high continuously -> back-to-back frames, busy low exactly one cycle between.
